// File: rtl/cntr_mod_if.sv
// Bundle of control inputs and status outputs for the cntr_mod up/down counter.
interface cntr_mod_if #(
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   en;
   logic                   up_dn;
   logic                   sat_mode;
   logic                   clr;
   logic                   load;
   logic [COUNT_WIDTH-1:0] load_val;
   logic                   ovf_clr;
   logic [COUNT_WIDTH-1:0] count;
   logic                   at_max;
   logic                   at_zero;
   logic                   wrap;
   logic                   sat_hit;
   logic                   ovf;

   modport master (
      output en, up_dn, sat_mode, clr, load, load_val, ovf_clr,
      input  count, at_max, at_zero, wrap, sat_hit, ovf
   );

   modport slave (
      input  en, up_dn, sat_mode, clr, load, load_val, ovf_clr,
      output count, at_max, at_zero, wrap, sat_hit, ovf
   );
endinterface

// File: rtl/cntr_mod.sv
// Up/down modulo counter with enable prescaler, clear/load, wrap or saturate
// boundary handling, one-cycle wrap/sat_hit pulses and a sticky ovf flag.
module cntr_mod #(
   parameter int unsigned COUNT_WIDTH = 8,
   parameter int unsigned MAX_VAL     = 2**COUNT_WIDTH - 1,
   parameter int unsigned PRESCALE    = 1
) (
   input logic         clk,
   input logic         rst_n,
   cntr_mod_if.slave   bus
);
   localparam int unsigned            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [COUNT_WIDTH-1:0] MAX_C   = COUNT_WIDTH'(MAX_VAL);
   localparam logic [PW-1:0]          PS_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]          pre;
   logic [COUNT_WIDTH-1:0] cnt;
   logic                   wrap_q;
   logic                   sat_q;
   logic                   ovf_q;
   logic                   tick;

   assign tick = bus.en && (pre == PS_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre    <= '0;
         cnt    <= '0;
         wrap_q <= 1'b0;
         sat_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         sat_q  <= 1'b0;
         // ovf_clr is applied first so that a same-edge event overrides it
         if (bus.ovf_clr)
            ovf_q <= 1'b0;
         if (bus.clr) begin
            cnt <= '0;
            pre <= '0;
         end else if (bus.load) begin
            cnt <= (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
            pre <= '0;
         end else if (bus.en) begin
            if (tick) begin
               pre <= '0;
               if (bus.up_dn) begin
                  if (cnt != MAX_C) begin
                     cnt <= cnt + COUNT_WIDTH'(1);
                  end else if (bus.sat_mode) begin
                     sat_q <= 1'b1;
                     ovf_q <= 1'b1;
                  end else begin
                     cnt    <= '0;
                     wrap_q <= 1'b1;
                     ovf_q  <= 1'b1;
                  end
               end else begin
                  if (cnt != '0) begin
                     cnt <= cnt - COUNT_WIDTH'(1);
                  end else if (bus.sat_mode) begin
                     sat_q <= 1'b1;
                     ovf_q <= 1'b1;
                  end else begin
                     cnt    <= MAX_C;
                     wrap_q <= 1'b1;
                     ovf_q  <= 1'b1;
                  end
               end
            end else begin
               pre <= pre + PW'(1);
            end
         end
      end
   end

   assign bus.count   = cnt;
   assign bus.at_max  = (cnt == MAX_C);
   assign bus.at_zero = (cnt == '0);
   assign bus.wrap    = wrap_q;
   assign bus.sat_hit = sat_q;
   assign bus.ovf     = ovf_q;
endmodule
